// File: rtl/bitcoin_nonce_sequencer.sv
// bitcoin_nonce_sequencer
// Sequences the two SHA-256 passes of a Bitcoin double hash for a range of
// nonces. The first pass runs the padded second header block from the
// supplied midstate; the second pass hashes that 256-bit digest from the
// standard IV. Each finished (nonce, hash) pair is offered on a valid/ready
// result port. The sequencer owns the core's start/done handshake and keeps
// the core input buses frozen outside SETUP.

module bitcoin_nonce_sequencer #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] midstate           [0:7],
    input  logic [31:0] tail               [0:2],
    input  logic [31:0] nonce_base,
    output logic        done,
    output logic        core_start,
    output logic [31:0] core_input_hash    [0:7],
    output logic [31:0] core_input_message [0:15],
    input  logic        core_done,
    input  logic [31:0] core_output_hash   [0:7],
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_nonce,
    output logic [31:0] res_hash           [0:7]
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] LAUNCH = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] EMIT   = 3'd4;

    localparam logic [15:0] LAST_COUNT = 16'(NUM_NONCES - 1);

    // Padding words: 80-byte header is 640 bits, the inner digest is 256 bits.
    localparam logic [31:0] PAD_ONE     = 32'h80000000;
    localparam logic [31:0] LEN_HEADER  = 32'd640;
    localparam logic [31:0] LEN_DIGEST  = 32'd256;

    localparam logic [31:0] SHA_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic [2:0]  state;
    logic [31:0] nonce;
    logic [15:0] count;
    logic        phase;
    logic [31:0] midstate_q [0:7];
    logic [31:0] tail_q     [0:2];

    // Status and handshake strobes are pure decodes of the state register.
    assign done       = (state == IDLE);
    assign core_start = (state == LAUNCH);
    assign res_valid  = (state == EMIT);

    // Main sequencer: run latching, block construction, core handshake and result hand-off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            nonce     <= '0;
            count     <= '0;
            phase     <= 1'b0;
            res_nonce <= '0;
            for (int i = 0; i < 8; i++) begin
                res_hash[i]        <= '0;
                core_input_hash[i] <= '0;
                midstate_q[i]      <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                core_input_message[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                tail_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A busy core would corrupt the first pass, so start waits for core_done.
                    if (start && core_done) begin
                        midstate_q <= midstate;
                        tail_q     <= tail;
                        nonce      <= nonce_base;
                        count      <= '0;
                        phase      <= 1'b0;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    if (!phase) begin
                        core_input_message[0] <= tail_q[0];
                        core_input_message[1] <= tail_q[1];
                        core_input_message[2] <= tail_q[2];
                        core_input_message[3] <= nonce;
                        core_input_message[4] <= PAD_ONE;
                        for (int i = 5; i < 15; i++) begin
                            core_input_message[i] <= '0;
                        end
                        core_input_message[15] <= LEN_HEADER;
                        core_input_hash        <= midstate_q;
                    end else begin
                        // The core still holds the first-pass digest while it sits idle.
                        for (int i = 0; i < 8; i++) begin
                            core_input_message[i] <= core_output_hash[i];
                        end
                        core_input_message[8] <= PAD_ONE;
                        for (int i = 9; i < 15; i++) begin
                            core_input_message[i] <= '0;
                        end
                        core_input_message[15] <= LEN_DIGEST;
                        core_input_hash        <= SHA_IV;
                    end
                    state <= LAUNCH;
                end

                LAUNCH: begin
                    // core_done is still high here; WAIT starts once the core has left idle.
                    state <= WAIT;
                end

                WAIT: begin
                    if (core_done) begin
                        if (!phase) begin
                            phase <= 1'b1;
                            state <= SETUP;
                        end else begin
                            res_hash  <= core_output_hash;
                            res_nonce <= nonce;
                            state     <= EMIT;
                        end
                    end
                end

                EMIT: begin
                    if (res_ready) begin
                        if (count == LAST_COUNT) begin
                            state <= IDLE;
                        end else begin
                            nonce <= nonce + 32'd1;
                            count <= count + 16'd1;
                            phase <= 1'b0;
                            state <= SETUP;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitcoin_nonce_sequencer.sv
// tb_bitcoin_nonce_sequencer
// Directed bench for the nonce sequencer with a behavioural SHA-256 core.
// Expected (nonce, double-hash) pairs are queued when a run is started and
// popped when the sequencer hands a result over.

module tb_bitcoin_nonce_sequencer;

    localparam int N       = 16;
    localparam int CORE_LAT = 12;

    localparam logic [255:0] IV_P = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct packed {
        logic [31:0]  nonce;
        logic [255:0] hash;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] midstate           [0:7];
    logic [31:0] tail               [0:2];
    logic [31:0] nonce_base;
    logic        done;
    logic        core_start;
    logic [31:0] core_input_hash    [0:7];
    logic [31:0] core_input_message [0:15];
    logic        core_done;
    logic [31:0] core_output_hash   [0:7];
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_nonce;
    logic [31:0] res_hash           [0:7];

    logic [255:0] cih_p, rh_p, core_out_p;
    logic [511:0] cim_p;

    logic [31:0]  hdr [0:18];
    logic [255:0] mid_p;

    exp_t         exp_q    [$];
    logic [255:0] launch_h [$];
    logic [511:0] launch_m [$];

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    logic [255:0] start_h, cap_h;
    logic [511:0] start_m, cap_m;
    int           busy_cnt;
    logic         unstable = 1'b0;
    logic         spurious = 1'b0;

    bitcoin_nonce_sequencer #(.NUM_NONCES(N)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .midstate           (midstate),
        .tail               (tail),
        .nonce_base         (nonce_base),
        .done               (done),
        .core_start         (core_start),
        .core_input_hash    (core_input_hash),
        .core_input_message (core_input_message),
        .core_done          (core_done),
        .core_output_hash   (core_output_hash),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_nonce          (res_nonce),
        .res_hash           (res_hash)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e,  hin[95:64] + f,   hin[63:32] + g,    hin[31:0] + h};
    endfunction

    function automatic logic [255:0] first_pass(input logic [31:0] nonce);
        return sha_compress(mid_p, {hdr[16], hdr[17], hdr[18], nonce, 32'h80000000, 320'd0, 32'd640});
    endfunction

    function automatic logic [255:0] golden(input logic [31:0] nonce);
        return sha_compress(IV_P, {first_pass(nonce), 32'h80000000, 192'd0, 32'd256});
    endfunction

    // Flatten array buses so they can be compared and stored as single vectors.
    always_comb begin
        cih_p = '0;
        rh_p  = '0;
        cim_p = '0;
        for (int i = 0; i < 8; i++) begin
            cih_p[255 - 32*i -: 32] = core_input_hash[i];
            rh_p[255 - 32*i -: 32]  = res_hash[i];
            core_output_hash[i]     = core_out_p[255 - 32*i -: 32];
        end
        for (int i = 0; i < 16; i++) cim_p[511 - 32*i -: 32] = core_input_message[i];
    end

    // Behavioural core: leaves idle on start, samples inputs late, flags unstable inputs.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_done  <= 1'b1;
            busy_cnt   <= 0;
            core_out_p <= '0;
        end else if (core_done) begin
            if (core_start) begin
                core_done <= 1'b0;
                busy_cnt  <= CORE_LAT;
                start_h   <= cih_p;
                start_m   <= cim_p;
            end
        end else begin
            if (core_start) spurious <= 1'b1;
            if (cih_p !== start_h || cim_p !== start_m) unstable <= 1'b1;
            if (busy_cnt == CORE_LAT - 3) begin
                cap_h <= cih_p;
                cap_m <= cim_p;
            end
            if (busy_cnt == 1) begin
                core_done  <= 1'b1;
                core_out_p <= sha_compress(cap_h, cap_m);
            end
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Record every launch so block contents can be checked after a run.
    always @(posedge clk) begin
        if (core_start) begin
            pulse_cnt <= pulse_cnt + 1;
            launch_h.push_back(cih_p);
            launch_m.push_back(cim_p);
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    // Scoreboard: each accepted result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", {255'd0, res_valid}, 256'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("res_nonce", {224'd0, res_nonce}, {224'd0, e.nonce});
                checkOutput("res_hash", rh_p, e.hash);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] base);
        exp_t e;
        nonce_base = base;
        for (int i = 0; i < N; i++) begin
            e.nonce = base + 32'(i);
            e.hash  = golden(e.nonce);
            exp_q.push_back(e);
        end
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 4000 && !done; i++) @(posedge clk) #1;
        checkOutput(tag, {255'd0, done}, 256'd1);
    endtask

    task automatic waitCoreBusy();
        for (int i = 0; i < 200 && core_done; i++) @(posedge clk) #1;
        checkOutput("core_went_busy", {255'd0, core_done}, 256'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not terminate");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int           l0, p0;
        logic [511:0] m;
        logic [31:0]  hold_nonce;
        logic [255:0] hold_hash;
        logic         stable;

        reset_n    = 1'b0;
        start      = 1'b0;
        res_ready  = 1'b1;
        nonce_base = '0;
        for (int i = 0; i < 19; i++) hdr[i] = $urandom;
        mid_p = sha_compress(IV_P, {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5], hdr[6], hdr[7],
                                    hdr[8], hdr[9], hdr[10], hdr[11], hdr[12], hdr[13], hdr[14], hdr[15]});
        for (int i = 0; i < 8; i++) midstate[i] = mid_p[255 - 32*i -: 32];
        for (int i = 0; i < 3; i++) tail[i] = hdr[16 + i];

        // Reference model sanity: SHA-256("abc").
        checkOutput("sha_model_abc", sha_compress(IV_P, {32'h61626380, 448'd0, 32'h00000018}),
                    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_done", {255'd0, done}, 256'd1);
        checkOutput("reset_res_valid", {255'd0, res_valid}, 256'd0);
        checkOutput("reset_core_start", {255'd0, core_start}, 256'd0);
        checkOutput("reset_res_nonce", {224'd0, res_nonce}, 256'd0);
        checkOutput("reset_res_hash", rh_p, 256'd0);
        checkOutput("reset_core_hash", cih_p, 256'd0);
        checkOutput("reset_core_msg_lo", cim_p[255:0], 256'd0);
        checkOutput("reset_core_msg_hi", cim_p[511:256], 256'd0);
        reset_n = 1'b1;
        @(posedge clk) #1;

        $display("[TB] run A: base 0x00000005, full-rate handshake");
        l0 = launch_m.size();
        p0 = pulse_cnt;
        applyStimulus(32'h00000005);
        checkOutput("done_falls", {255'd0, done}, 256'd0);
        waitDone("runA_done");
        @(posedge clk) #1;
        checkOutput("runA_queue_empty", 256'(exp_q.size()), 256'd0);
        checkOutput("runA_pulses", 256'(pulse_cnt - p0), 256'd32);
        m = launch_m[l0];
        checkOutput("p0_word3", {224'd0, m[511 - 32*3 -: 32]}, 256'h5);
        checkOutput("p0_word4", {224'd0, m[511 - 32*4 -: 32]}, 256'h80000000);
        checkOutput("p0_word15", {224'd0, m[31:0]}, 256'h280);
        checkOutput("p0_hash", launch_h[l0], mid_p);
        m = launch_m[l0 + 1];
        checkOutput("p1_digest", m[511:256], first_pass(32'h5));
        checkOutput("p1_word8", {224'd0, m[511 - 32*8 -: 32]}, 256'h80000000);
        checkOutput("p1_word15", {224'd0, m[31:0]}, 256'h100);
        checkOutput("p1_hash_iv", launch_h[l0 + 1], IV_P);

        $display("[TB] run B: wrap from 0xFFFFFFFE with backpressure on first result");
        res_ready = 1'b0;
        p0 = pulse_cnt;
        applyStimulus(32'hFFFFFFFE);
        for (int i = 0; i < 2000 && !res_valid; i++) @(posedge clk) #1;
        checkOutput("bp_valid_seen", {255'd0, res_valid}, 256'd1);
        hold_nonce = res_nonce;
        hold_hash  = rh_p;
        p0         = pulse_cnt;
        stable     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk) #1;
            if (!res_valid || res_nonce !== hold_nonce || rh_p !== hold_hash) stable = 1'b0;
        end
        checkOutput("bp_stable", {255'd0, stable}, 256'd1);
        checkOutput("bp_no_launch", 256'(pulse_cnt - p0), 256'd0);
        checkOutput("bp_held_nonce", {224'd0, hold_nonce}, 256'hFFFFFFFE);
        res_ready = 1'b1;
        for (int i = 0; i < 10 && pulse_cnt == p0; i++) @(posedge clk) #1;
        checkOutput("bp_next_launch", 256'(pulse_cnt - p0), 256'd1);
        waitDone("runB_done");
        @(posedge clk) #1;
        checkOutput("runB_queue_empty", 256'(exp_q.size()), 256'd0);

        $display("[TB] run C: start pulsed while busy");
        applyStimulus(32'h00000100);
        waitCoreBusy();
        nonce_base = 32'hDEAD0000;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        checkOutput("busy_done_low", {255'd0, done}, 256'd0);
        waitDone("runC_done");
        @(posedge clk) #1;
        checkOutput("runC_queue_empty", 256'(exp_q.size()), 256'd0);

        $display("[TB] run D: reset mid-WAIT");
        applyStimulus(32'h00000040);
        waitCoreBusy();
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_done", {255'd0, done}, 256'd1);
        checkOutput("midreset_res_valid", {255'd0, res_valid}, 256'd0);
        checkOutput("midreset_core_start", {255'd0, core_start}, 256'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk) #1;
        checkOutput("postreset_idle", {255'd0, done}, 256'd1);

        $display("[TB] run E: clean run after reset");
        p0 = pulse_cnt;
        applyStimulus(32'h00000007);
        waitDone("runE_done");
        @(posedge clk) #1;
        checkOutput("runE_queue_empty", 256'(exp_q.size()), 256'd0);
        checkOutput("runE_pulses", 256'(pulse_cnt - p0), 256'd32);
        checkOutput("inputs_stable_in_run", {255'd0, unstable}, 256'd0);
        checkOutput("single_cycle_start", {255'd0, spurious}, 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
